// File: rtl/openofdm_rx_stat_if.sv
// Bundle of the decode-event inputs, control strobes and the addressed read port
// shared between openofdm_rx_stat and whatever drives it.
interface openofdm_rx_stat_if #(
    parameter int STATE_WIDTH = 5,
    parameter int TO_WIDTH    = 24
);
    logic                   enable;
    logic                   clear;
    logic                   snapshot;
    logic                   short_preamble_detected;
    logic                   long_preamble_detected;
    logic                   pkt_header_valid_strobe;
    logic                   ht_unsupport;
    logic                   fcs_out_strobe;
    logic                   fcs_ok;
    logic [STATE_WIDTH-1:0] state;
    logic                   state_changed;
    logic [TO_WIDTH-1:0]    timeout_cycles;
    logic [3:0]             rd_addr;
    logic [31:0]            rd_data;
    logic [31:0]            state_history;
    logic                   timeout_pulse;

    modport master (
        output enable, clear, snapshot, short_preamble_detected, long_preamble_detected,
               pkt_header_valid_strobe, ht_unsupport, fcs_out_strobe, fcs_ok, state,
               state_changed, timeout_cycles, rd_addr,
        input  rd_data, state_history, timeout_pulse
    );

    modport slave (
        input  enable, clear, snapshot, short_preamble_detected, long_preamble_detected,
               pkt_header_valid_strobe, ht_unsupport, fcs_out_strobe, fcs_ok, state,
               state_changed, timeout_cycles, rd_addr,
        output rd_data, state_history, timeout_pulse
    );
endinterface

// File: rtl/openofdm_rx_stat.sv
// Receive statistics for the dot11 decoder: saturating event counters with a shadow
// set, a decoder-state history, a stuck-state watchdog and a registered read port.
module openofdm_rx_stat #(
    parameter int CNT_WIDTH   = 32,
    parameter int STATE_WIDTH = 5,
    parameter int HIST_DEPTH  = 6,
    parameter int IDLE_STATE  = 0,
    parameter int TO_WIDTH    = 24
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    openofdm_rx_stat_if.slave bus
);
    localparam int NUM_CNT   = 7;
    localparam int HIST_BITS = HIST_DEPTH * STATE_WIDTH;
    localparam int CNT_EXT   = (CNT_WIDTH < 32) ? CNT_WIDTH : 32;
    localparam int TO_EXT    = (TO_WIDTH < 32) ? TO_WIDTH : 32;

    localparam logic [CNT_WIDTH-1:0]   CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [TO_WIDTH-1:0]    TO_ZERO   = {TO_WIDTH{1'b0}};
    localparam logic [TO_WIDTH-1:0]    TO_ONE    = {{(TO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TO_WIDTH-1:0]    TO_MAX    = {TO_WIDTH{1'b1}};
    localparam logic [HIST_BITS-1:0]   HIST_ZERO = {HIST_BITS{1'b0}};
    localparam logic [STATE_WIDTH-1:0] IDLE_CODE = STATE_WIDTH'(IDLE_STATE);

    logic                 short_d_r;
    logic                 long_d_r;
    logic                 ht_d_r;
    logic [CNT_WIDTH-1:0] cnt_r    [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_r [NUM_CNT];
    logic [HIST_BITS-1:0] hist_r;
    logic [TO_WIDTH-1:0]  dwell_r;
    logic                 fired_r;
    logic                 timeout_pulse_r;
    logic [31:0]          rd_data_r;

    logic [NUM_CNT-1:0]   inc_s;
    logic                 fire_s;
    logic                 dwell_rst_s;
    logic [HIST_BITS-1:0] state_ext_s;
    logic [31:0]          hist_ext_s;
    logic [31:0]          rd_mux_s;

    function automatic logic [31:0] cnt_to_word(input logic [CNT_WIDTH-1:0] v);
        cnt_to_word = 32'd0;
        cnt_to_word[CNT_EXT-1:0] = v[CNT_EXT-1:0];
    endfunction

    function automatic logic [31:0] dwell_to_word(input logic [TO_WIDTH-1:0] v);
        dwell_to_word = 32'd0;
        dwell_to_word[TO_EXT-1:0] = v[TO_EXT-1:0];
    endfunction

    // Decode increment requests and watchdog expiry; nothing counts while disabled
    always_comb begin
        inc_s       = {NUM_CNT{1'b0}};
        fire_s      = 1'b0;
        dwell_rst_s = (bus.state == IDLE_CODE) || bus.state_changed;
        if (bus.enable) begin
            fire_s   = (bus.timeout_cycles != TO_ZERO) && (dwell_r == bus.timeout_cycles) && !fired_r;
            inc_s[0] = bus.short_preamble_detected & ~short_d_r;
            inc_s[1] = bus.long_preamble_detected & ~long_d_r;
            inc_s[2] = bus.pkt_header_valid_strobe;
            inc_s[3] = bus.ht_unsupport & ~ht_d_r;
            inc_s[4] = bus.fcs_out_strobe & bus.fcs_ok;
            inc_s[5] = bus.fcs_out_strobe & ~bus.fcs_ok;
            inc_s[6] = fire_s;
        end else begin
            inc_s  = {NUM_CNT{1'b0}};
            fire_s = 1'b0;
        end
    end

    // Previous-cycle copies of level inputs, tracked regardless of enable
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            short_d_r <= 1'b0;
            long_d_r  <= 1'b0;
            ht_d_r    <= 1'b0;
        end else begin
            short_d_r <= bus.short_preamble_detected;
            long_d_r  <= bus.long_preamble_detected;
            ht_d_r    <= bus.ht_unsupport;
        end
    end

    // Live counters: clear beats any same-cycle event, increments saturate
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_r[i] <= CNT_ZERO;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (bus.clear) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (inc_s[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Shadow set captures live values as they stood before this edge
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_r[i] <= CNT_ZERO;
        end else if (bus.snapshot) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_r[i] <= cnt_r[i];
        end
    end

    // Zero-extend the incoming state and the packed history to their target widths
    always_comb begin
        state_ext_s = HIST_ZERO;
        state_ext_s[STATE_WIDTH-1:0] = bus.state;
        hist_ext_s = 32'd0;
        hist_ext_s[HIST_BITS-1:0] = hist_r;
    end

    // History shift register, newest entry in the LSBs; the shift drops the oldest
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            hist_r <= HIST_ZERO;
        end else if (bus.enable && bus.state_changed) begin
            hist_r <= (hist_r << STATE_WIDTH) | state_ext_s;
        end
    end

    // Dwell counter and one-shot expiry; fired_r blocks re-fire until dwell restarts
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            dwell_r         <= TO_ZERO;
            fired_r         <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            timeout_pulse_r <= fire_s;
            if (bus.enable) begin
                if (dwell_rst_s) begin
                    dwell_r <= TO_ZERO;
                    fired_r <= 1'b0;
                end else begin
                    if (dwell_r != TO_MAX) dwell_r <= dwell_r + TO_ONE;
                    if (fire_s) fired_r <= 1'b1;
                end
            end
        end
    end

    // Read select
    always_comb begin
        rd_mux_s = 32'd0;
        case (bus.rd_addr)
            4'd0:    rd_mux_s = cnt_to_word(shadow_r[0]);
            4'd1:    rd_mux_s = cnt_to_word(shadow_r[1]);
            4'd2:    rd_mux_s = cnt_to_word(shadow_r[2]);
            4'd3:    rd_mux_s = cnt_to_word(shadow_r[3]);
            4'd4:    rd_mux_s = cnt_to_word(shadow_r[4]);
            4'd5:    rd_mux_s = cnt_to_word(shadow_r[5]);
            4'd6:    rd_mux_s = cnt_to_word(shadow_r[6]);
            4'd7:    rd_mux_s = hist_ext_s;
            4'd8:    rd_mux_s = dwell_to_word(dwell_r);
            4'd9:    rd_mux_s = cnt_to_word(cnt_r[5]);
            4'd10:   rd_mux_s = {27'd0, bus.enable, (bus.timeout_cycles != TO_ZERO), 3'd0};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read data register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_data_r <= 32'd0;
        end else begin
            rd_data_r <= rd_mux_s;
        end
    end

    assign bus.rd_data       = rd_data_r;
    assign bus.state_history = hist_ext_s;
    assign bus.timeout_pulse = timeout_pulse_r;
endmodule
